wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and integer register file for the 5-stage RISC-V core. Consumes the MA/WB pipeline register outputs, selects the write-back result, commits it to a 32 x 32-bit register file, and serves the two decode-stage read ports with same-cycle write-to-read bypass. It also keeps a committed-write counter for debug and performance visibility.

## Interface
- No parameters. Fixed: XLEN = 32, 32 architectural registers, x0 hardwired to zero.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- W_alu_o  input  32  ALU result from MA/WB.
- W_dm_rd  input  32  data-memory read data from MA/WB.
- W_ext  input  32  extended immediate (LUI) from MA/WB.
- W_pc_p4  input  32  PC+4 (JAL/JALR link) from MA/WB.
- W_rf_a3  input  5  destination register address.
- W_we_rf  input  1  register-file write enable.
- W_sel_result  input  2  result select: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
- D_rf_a1  input  5  decode read address, port 1.
- D_rf_a2  input  5  decode read address, port 2.
- D_rf_rd1  output  32  read data, port 1 (combinational).
- D_rf_rd2  output  32  read data, port 2 (combinational).
- W_result  output  32  selected write-back value (combinational; feeds the forwarding muxes).
- wb_count  output  32  registered count of committed writes.

## Operation
- Result mux: W_result = W_alu_o / W_dm_rd / W_pc_p4 / W_ext for W_sel_result 00/01/10/11. Pure combinational. It is valid whenever the inputs are valid, regardless of W_we_rf.
- Commit condition: commit = W_we_rf && (W_rf_a3 != 0) && !rst.
- Write: on a rising edge with commit = 1, regs[W_rf_a3] <= W_result.
  - A write to x0 is discarded.
  - x0 always reads 0.
- Read, port n:
  - Address 0 -> 0.
  - Otherwise, if commit and D_rf_an == W_rf_a3 -> W_result (write-first bypass).
  - Otherwise -> regs[D_rf_an].
- Both ports may read the same address, including the address being written. Both then return the bypassed value.
- wb_count:
  - Increments by 1 on each edge where commit = 1.
  - Wraps from 0xFFFF_FFFF to 0 with no flag.
  - Writes to x0 and cycles with W_we_rf = 0 are not counted.
- Reset (rst = 1 at a rising edge):
  - All 31 writable registers clear to 0.
  - wb_count clears to 0.
  - A write presented in the same cycle is dropped. Reset has priority.
- While rst is high:
  - Bypass is suppressed, so D_rf_rd1/2 reflect array contents only. These are 0 after the first reset edge.
  - W_result still follows the mux.

## Timing
- Write latency: 1 edge. A value written at edge k is returned from the array from cycle k onward.
- The same value is visible through bypass during the cycle before edge k. A decode-stage read in the same cycle as the WB write therefore sees the new value, and no extra WB->ID forwarding path is needed.
- Read ports have zero latency: a combinational path from D_rf_an/W inputs to D_rf_rdn.
- wb_count reflects all commits up to and including the most recent edge.
- Reset values after the first reset edge:
  - Every register = 0.
  - wb_count = 0.
  - D_rf_rd1 = D_rf_rd2 = 0.
  - W_result follows its inputs.
- Back-to-back writes to the same register: the last write wins. Each one is counted.
- Reset mid-stream: the commit in the reset cycle is lost. Commits resume on the first edge with rst = 0.

## Test plan
- Reset: preload x5 = 0x1234 and wb_count = 3, assert rst for 1 cycle -> D_rf_rd1(a1 = 5) = 0 and wb_count = 0 on the next cycle.
- Result mux: alu = 0xA, dm = 0xB, pc4 = 0xC, ext = 0xD; step sel 00..11 with we = 1 and a3 = 1..4 -> x1..x4 read 0xA, 0xB, 0xC, 0xD; wb_count = 4.
- Bypass: we = 1, a3 = 7, result 0xDEAD_BEEF, a1 = a2 = 7 in the same cycle -> both ports read 0xDEAD_BEEF before the edge and after it.
- x0: we = 1, a3 = 0, result 0xFFFF_FFFF -> reads of x0 give 0 in the same cycle and the next; wb_count unchanged.
- Simultaneous reset and write: rst = 1, we = 1, a3 = 9, result 0x55 -> after the edge x9 = 0 and wb_count = 0.
- Counter wrap: force 0xFFFF_FFFF commits (or preload via the backdoor) and apply one more commit -> wb_count = 0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Write-back / register-file bus.
// The master drives the MA/WB pipeline outputs and the decode read addresses.
// The slave (wb_regfile) returns the read data, the selected write-back value
// and the commit counter.
interface wb_regfile_if;
  logic [31:0] W_alu_o;
  logic [31:0] W_dm_rd;
  logic [31:0] W_ext;
  logic [31:0] W_pc_p4;
  logic [4:0]  W_rf_a3;
  logic        W_we_rf;
  logic [1:0]  W_sel_result;
  logic [4:0]  D_rf_a1;
  logic [4:0]  D_rf_a2;
  logic [31:0] D_rf_rd1;
  logic [31:0] D_rf_rd2;
  logic [31:0] W_result;
  logic [31:0] wb_count;

  modport master (
    output W_alu_o, W_dm_rd, W_ext, W_pc_p4, W_rf_a3, W_we_rf, W_sel_result,
    output D_rf_a1, D_rf_a2,
    input  D_rf_rd1, D_rf_rd2, W_result, wb_count
  );

  modport slave (
    input  W_alu_o, W_dm_rd, W_ext, W_pc_p4, W_rf_a3, W_we_rf, W_sel_result,
    input  D_rf_a1, D_rf_a2,
    output D_rf_rd1, D_rf_rd2, W_result, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and 32 x 32 integer register file.
// x0 reads as zero and ignores writes. Both decode read ports bypass the
// value being committed this cycle (write-first), so decode sees the
// write-back result without a separate WB->ID forwarding path.
// A free-running counter tracks committed writes.
module wb_regfile (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] wb_count_q;
  logic [XLEN-1:0] wb_count_d;
  logic [XLEN-1:0] result;
  logic            commit;

  // Read-port value: x0 is zero; the in-flight commit wins over the array.
  function automatic logic [XLEN-1:0] read_port(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] stored,
    input logic            cmt,
    input logic [4:0]      wr_addr,
    input logic [XLEN-1:0] wr_data
  );
    if (addr == 5'd0)                   return '0;
    else if (cmt && (addr == wr_addr))  return wr_data;
    else                                return stored;
  endfunction

  // Write-back result select; independent of the write enable.
  always_comb begin
    case (bus.W_sel_result)
      2'b00:   result = bus.W_alu_o;
      2'b01:   result = bus.W_dm_rd;
      2'b10:   result = bus.W_pc_p4;
      default: result = bus.W_ext;
    endcase
  end

  // Reset suppresses the commit, which also disables the bypass paths.
  assign commit = bus.W_we_rf && (bus.W_rf_a3 != 5'd0) && !rst;

  // Next array and counter state for a commit.
  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    wb_count_d = wb_count_q;
    if (commit) begin
      regs_d[bus.W_rf_a3] = result;
      wb_count_d          = wb_count_q + 32'd1;
    end
    regs_d[0] = '0;
  end

  // Register array and counter; reset clears both and drops any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      wb_count_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      wb_count_q <= wb_count_d;
    end
  end

  // Combinational read ports and outputs.
  always_comb begin
    bus.D_rf_rd1 = read_port(bus.D_rf_a1, regs_q[bus.D_rf_a1], commit, bus.W_rf_a3, result);
    bus.D_rf_rd2 = read_port(bus.D_rf_a2, regs_q[bus.D_rf_a2], commit, bus.W_rf_a3, result);
    bus.W_result = result;
    bus.wb_count = wb_count_q;
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: expected values are queued when the
// stimulus is applied and popped against the DUT outputs when sampled.
module tb_wb_regfile;
  logic clk;
  logic rst;
  wb_regfile_if bus ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] obs [$];
  int          checks;
  int          errors;
  logic [31:0] model_regs [32];
  logic [31:0] model_count;

  // Advance one clock: inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic idle_bus();
    bus.W_alu_o      = '0;
    bus.W_dm_rd      = '0;
    bus.W_ext        = '0;
    bus.W_pc_p4      = '0;
    bus.W_rf_a3      = '0;
    bus.W_we_rf      = 1'b0;
    bus.W_sel_result = 2'b00;
    bus.D_rf_a1      = '0;
    bus.D_rf_a2      = '0;
  endtask

  // Commit one ALU-selected write and update the model.
  task automatic do_write(input logic [4:0] a3, input logic [31:0] val);
    bus.W_alu_o      = val;
    bus.W_sel_result = 2'b00;
    bus.W_rf_a3      = a3;
    bus.W_we_rf      = 1'b1;
    tick();
    bus.W_we_rf = 1'b0;
    if (a3 != 5'd0) begin
      model_regs[a3] = val;
      model_count    = model_count + 32'd1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_count = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    tick();
    rst = 1'b0;
    model_reset();
    expect_val("reset_count", 32'd0);
    expect_val("reset_rd1_x0", 32'd0);
    obs.push_back(bus.wb_count);
    obs.push_back(bus.D_rf_rd1);
    do_write(5'd5, 32'h0000_1234);
    do_write(5'd6, 32'h0000_0006);
    do_write(5'd8, 32'h0000_0008);
    bus.D_rf_a1 = 5'd5;
    #1;
    expect_val("preload_x5", 32'h0000_1234);
    expect_val("preload_count", 32'd3);
    obs.push_back(bus.D_rf_rd1);
    obs.push_back(bus.wb_count);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    expect_val("after_rst_x5", 32'd0);
    expect_val("after_rst_count", 32'd0);
    obs.push_back(bus.D_rf_rd1);
    obs.push_back(bus.wb_count);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] got = obs.pop_front();
      checks++;
      if (got !== e.val) begin
        $display("FAIL %s got %h expected %h", e.name, got, e.val);
        errors++;
      end
    end
  endtask

  task automatic test_result_mux();
    logic [31:0] vals [4];
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC; vals[3] = 32'hD;
    bus.W_alu_o = 32'hA;
    bus.W_dm_rd = 32'hB;
    bus.W_pc_p4 = 32'hC;
    bus.W_ext   = 32'hD;
    for (int s = 0; s < 4; s++) begin
      bus.W_sel_result = 2'(s);
      bus.W_rf_a3      = 5'(s + 1);
      bus.W_we_rf      = 1'b1;
      #1;
      expect_val($sformatf("mux_result_sel%0d", s), vals[s]);
      obs.push_back(bus.W_result);
      tick();
      model_regs[s + 1] = vals[s];
      model_count       = model_count + 32'd1;
    end
    bus.W_we_rf = 1'b0;
    bus.W_sel_result = 2'b01;
    #1;
    expect_val("mux_result_no_we", 32'hB);
    obs.push_back(bus.W_result);
    for (int r = 1; r <= 4; r++) begin
      bus.D_rf_a1 = 5'(r);
      bus.D_rf_a2 = 5'(5 - r);
      #1;
      expect_val($sformatf("mux_x%0d_rd1", r), model_regs[r]);
      expect_val($sformatf("mux_x%0d_rd2", 5 - r), model_regs[5 - r]);
      obs.push_back(bus.D_rf_rd1);
      obs.push_back(bus.D_rf_rd2);
    end
    expect_val("mux_count", 32'd4);
    obs.push_back(bus.wb_count);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] got = obs.pop_front();
      checks++;
      if (got !== e.val) begin
        $display("FAIL %s got %h expected %h", e.name, got, e.val);
        errors++;
      end
    end
  endtask

  task automatic test_bypass();
    bus.W_alu_o      = 32'hDEAD_BEEF;
    bus.W_sel_result = 2'b00;
    bus.W_rf_a3      = 5'd7;
    bus.W_we_rf      = 1'b1;
    bus.D_rf_a1      = 5'd7;
    bus.D_rf_a2      = 5'd7;
    #1;
    expect_val("bypass_pre_rd1", 32'hDEAD_BEEF);
    expect_val("bypass_pre_rd2", 32'hDEAD_BEEF);
    obs.push_back(bus.D_rf_rd1);
    obs.push_back(bus.D_rf_rd2);
    tick();
    bus.W_we_rf = 1'b0;
    bus.W_alu_o = 32'h0;
    model_regs[7] = 32'hDEAD_BEEF;
    model_count   = model_count + 32'd1;
    #1;
    expect_val("bypass_post_rd1", 32'hDEAD_BEEF);
    expect_val("bypass_post_rd2", 32'hDEAD_BEEF);
    expect_val("bypass_count", model_count);
    obs.push_back(bus.D_rf_rd1);
    obs.push_back(bus.D_rf_rd2);
    obs.push_back(bus.wb_count);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] got = obs.pop_front();
      checks++;
      if (got !== e.val) begin
        $display("FAIL %s got %h expected %h", e.name, got, e.val);
        errors++;
      end
    end
  endtask

  task automatic test_x0();
    bus.W_alu_o      = 32'hFFFF_FFFF;
    bus.W_sel_result = 2'b00;
    bus.W_rf_a3      = 5'd0;
    bus.W_we_rf      = 1'b1;
    bus.D_rf_a1      = 5'd0;
    bus.D_rf_a2      = 5'd0;
    #1;
    expect_val("x0_pre_rd1", 32'd0);
    expect_val("x0_pre_rd2", 32'd0);
    obs.push_back(bus.D_rf_rd1);
    obs.push_back(bus.D_rf_rd2);
    tick();
    bus.W_we_rf = 1'b0;
    #1;
    expect_val("x0_post_rd1", 32'd0);
    expect_val("x0_post_rd2", 32'd0);
    expect_val("x0_count", model_count);
    obs.push_back(bus.D_rf_rd1);
    obs.push_back(bus.D_rf_rd2);
    obs.push_back(bus.wb_count);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] got = obs.pop_front();
      checks++;
      if (got !== e.val) begin
        $display("FAIL %s got %h expected %h", e.name, got, e.val);
        errors++;
      end
    end
  endtask

  task automatic test_reset_with_write();
    do_write(5'd9, 32'h0000_0077);
    bus.W_alu_o      = 32'h0000_0055;
    bus.W_sel_result = 2'b00;
    bus.W_rf_a3      = 5'd9;
    bus.W_we_rf      = 1'b1;
    bus.D_rf_a1      = 5'd9;
    bus.D_rf_a2      = 5'd9;
    rst = 1'b1;
    #1;
    expect_val("rstwr_no_bypass_rd1", 32'h0000_0077);
    expect_val("rstwr_result", 32'h0000_0055);
    obs.push_back(bus.D_rf_rd1);
    obs.push_back(bus.W_result);
    tick();
    model_reset();
    bus.W_we_rf = 1'b0;
    #1;
    expect_val("rstwr_still_rst_rd2", 32'd0);
    obs.push_back(bus.D_rf_rd2);
    rst = 1'b0;
    #1;
    expect_val("rstwr_x9", 32'd0);
    expect_val("rstwr_count", 32'd0);
    obs.push_back(bus.D_rf_rd1);
    obs.push_back(bus.wb_count);
    do_write(5'd9, 32'h0000_0066);
    expect_val("rstwr_resume_x9", 32'h0000_0066);
    expect_val("rstwr_resume_count", 32'd1);
    obs.push_back(bus.D_rf_rd1);
    obs.push_back(bus.wb_count);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] got = obs.pop_front();
      checks++;
      if (got !== e.val) begin
        $display("FAIL %s got %h expected %h", e.name, got, e.val);
        errors++;
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.D_rf_a1      = 5'd10;
    bus.D_rf_a2      = 5'd10;
    bus.W_sel_result = 2'b00;
    bus.W_rf_a3      = 5'd10;
    bus.W_we_rf      = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus.W_alu_o = 32'(k * 16'h1111);
      #1;
      expect_val($sformatf("b2b_bypass_%0d", k), 32'(k * 16'h1111));
      expect_val($sformatf("b2b_array_%0d", k), model_regs[10]);
      obs.push_back(bus.D_rf_rd2);
      obs.push_back(dut.regs_q[10]);
      tick();
      model_regs[10] = 32'(k * 16'h1111);
      model_count    = model_count + 32'd1;
    end
    bus.W_we_rf = 1'b0;
    #1;
    expect_val("b2b_last_wins", 32'h0000_3333);
    expect_val("b2b_count", model_count);
    obs.push_back(bus.D_rf_rd1);
    obs.push_back(bus.wb_count);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] got = obs.pop_front();
      checks++;
      if (got !== e.val) begin
        $display("FAIL %s got %h expected %h", e.name, got, e.val);
        errors++;
      end
    end
  endtask

  task automatic test_all_regs();
    for (int r = 1; r < 32; r++) do_write(5'(r), $urandom);
    for (int r = 0; r < 32; r++) begin
      bus.D_rf_a1 = 5'(r);
      bus.D_rf_a2 = 5'(31 - r);
      #1;
      expect_val($sformatf("all_rd1_x%0d", r), model_regs[r]);
      expect_val($sformatf("all_rd2_x%0d", 31 - r), model_regs[31 - r]);
      obs.push_back(bus.D_rf_rd1);
      obs.push_back(bus.D_rf_rd2);
    end
    expect_val("all_count", model_count);
    obs.push_back(bus.wb_count);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] got = obs.pop_front();
      checks++;
      if (got !== e.val) begin
        $display("FAIL %s got %h expected %h", e.name, got, e.val);
        errors++;
      end
    end
  endtask

  task automatic test_wrap();
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    #1;
    expect_val("wrap_preload", 32'hFFFF_FFFF);
    obs.push_back(bus.wb_count);
    do_write(5'd3, 32'h0000_0abc);
    expect_val("wrap_zero", 32'd0);
    obs.push_back(bus.wb_count);
    do_write(5'd0, 32'h0000_0001);
    do_write(5'd4, 32'h0000_0def);
    expect_val("wrap_one", 32'd1);
    obs.push_back(bus.wb_count);
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] got = obs.pop_front();
      checks++;
      if (got !== e.val) begin
        $display("FAIL %s got %h expected %h", e.name, got, e.val);
        errors++;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    model_reset();
    idle_bus();
    tick();
    test_reset();
    test_result_mux();
    test_bypass();
    test_x0();
    test_reset_with_write();
    test_back_to_back();
    test_all_regs();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
